// File: rtl/pdp_alu_pipe.sv
// Elastic, pipelined single-operand PDP-11 ALU: combinational ALU ahead of STAGES valid/ready
// registers. Define PDP_ALU_BYTE_EN to honour in_byte (xxxB ops); otherwise all ops are word.
module pdp_alu_pipe #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned STAGES = 2,
    parameter int unsigned OPC_W  = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [OPC_W-1:0]            in_op,
    input  logic                        in_byte,
    input  logic [DATA_W-1:0]           in_src,
    input  logic [3:0]                  in_psw,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_W-1:0]           out_result,
    output logic [3:0]                  out_psw,
    output logic                        out_illegal,
    output logic [$clog2(STAGES+1)-1:0] occupancy
);

    localparam int unsigned OCC_W = $clog2(STAGES + 1);
    localparam int unsigned PW    = DATA_W + 5;

    localparam logic [OPC_W-1:0] OpClr  = OPC_W'(0);
    localparam logic [OPC_W-1:0] OpCom  = OPC_W'(1);
    localparam logic [OPC_W-1:0] OpInc  = OPC_W'(2);
    localparam logic [OPC_W-1:0] OpDec  = OPC_W'(3);
    localparam logic [OPC_W-1:0] OpNeg  = OPC_W'(4);
    localparam logic [OPC_W-1:0] OpAdc  = OPC_W'(5);
    localparam logic [OPC_W-1:0] OpSbc  = OPC_W'(6);
    localparam logic [OPC_W-1:0] OpTst  = OPC_W'(7);
    localparam logic [OPC_W-1:0] OpRor  = OPC_W'(8);
    localparam logic [OPC_W-1:0] OpRol  = OPC_W'(9);
    localparam logic [OPC_W-1:0] OpAsr  = OPC_W'(10);
    localparam logic [OPC_W-1:0] OpAsl  = OPC_W'(11);
    localparam logic [OPC_W-1:0] OpSwab = OPC_W'(12);

    localparam logic [DATA_W-1:0] One = DATA_W'(1);

    logic byte_mode;
`ifdef PDP_ALU_BYTE_EN
    assign byte_mode = in_byte & (in_op != OpSwab);
`else
    logic unused_byte;
    assign unused_byte = in_byte;
    assign byte_mode   = 1'b0;
`endif

    logic [DATA_W-1:0] mask, msb_bit, s, r, alu_res;
    logic [3:0]        alu_psw;
    logic              cin, n, z, v, c, illegal, shift_op;

    // Operand-width handling is done with masks so one datapath serves byte and word.
    always_comb begin
        mask     = byte_mode ? DATA_W'(8'hFF) : '1;
        msb_bit  = mask & ~(mask >> 1);
        s        = in_src & mask;
        cin      = in_psw[0];
        r        = '0;
        v        = 1'b0;
        c        = 1'b0;
        illegal  = 1'b0;
        shift_op = 1'b0;
        case (in_op)
            OpClr: r = '0;
            OpCom: begin
                r = ~s & mask;
                c = 1'b1;
            end
            OpInc: begin
                r = (s + One) & mask;
                v = (s == (mask >> 1));
                c = cin;
            end
            OpDec: begin
                r = (s - One) & mask;
                v = (s == msb_bit);
                c = cin;
            end
            OpNeg: begin
                r = (~s + One) & mask;
                v = (r == msb_bit);
                c = (r != '0);
            end
            OpAdc: begin
                r = (s + DATA_W'(cin)) & mask;
                v = (s == (mask >> 1)) & cin;
                c = (s == mask) & cin;
            end
            OpSbc: begin
                r = (s - DATA_W'(cin)) & mask;
                v = (s == msb_bit) & cin;
                c = (s == '0) & cin;
            end
            OpTst: r = s;
            OpRor: begin
                r        = (s >> 1) | (cin ? msb_bit : '0);
                c        = s[0];
                shift_op = 1'b1;
            end
            OpRol: begin
                r        = ((s << 1) | DATA_W'(cin)) & mask;
                c        = |(s & msb_bit);
                shift_op = 1'b1;
            end
            OpAsr: begin
                r        = (s >> 1) | (s & msb_bit);
                c        = s[0];
                shift_op = 1'b1;
            end
            OpAsl: begin
                r        = (s << 1) & mask;
                c        = |(s & msb_bit);
                shift_op = 1'b1;
            end
            OpSwab: r = {in_src[DATA_W/2-1:0], in_src[DATA_W-1:DATA_W/2]};
            default: illegal = 1'b1;
        endcase
        n = |(r & msb_bit);
        z = (r == '0);
        if (in_op == OpSwab) begin
            // SWAB flags always come from the low byte of the swapped word.
            n = r[7];
            z = (r[7:0] == 8'h00);
        end
        if (shift_op) begin
            v = n ^ c;
        end
        alu_res = illegal ? in_src : ((in_src & ~mask) | r);
        alu_psw = illegal ? in_psw : {n, z, v, c};
    end

    logic [STAGES-1:0] vld_q, adv, load;
    logic [PW-1:0]     pay_q [STAGES];

    // Advance/load chain runs from the output back towards the input.
    always_comb begin
        adv               = '0;
        load              = '0;
        adv[STAGES-1]     = vld_q[STAGES-1] & out_ready;
        load[STAGES-1]    = ~vld_q[STAGES-1] | adv[STAGES-1];
        for (int k = int'(STAGES) - 2; k >= 0; k--) begin
            adv[k]  = vld_q[k] & load[k+1];
            load[k] = ~vld_q[k] | adv[k];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_q <= '0;
            for (int k = 0; k < int'(STAGES); k++) begin
                pay_q[k] <= '0;
            end
        end else begin
            if (load[0]) begin
                vld_q[0] <= in_valid;
                if (in_valid) begin
                    pay_q[0] <= {illegal, alu_psw, alu_res};
                end
            end
            for (int k = 1; k < int'(STAGES); k++) begin
                if (load[k]) begin
                    vld_q[k] <= vld_q[k-1];
                    if (vld_q[k-1]) begin
                        pay_q[k] <= pay_q[k-1];
                    end
                end
            end
        end
    end

    always_comb begin
        occupancy = '0;
        for (int k = 0; k < int'(STAGES); k++) begin
            occupancy = occupancy + OCC_W'(vld_q[k]);
        end
    end

    assign in_ready                              = load[0];
    assign out_valid                             = vld_q[STAGES-1];
    assign {out_illegal, out_psw, out_result}    = pay_q[STAGES-1];

endmodule

// File: tb/tb_pdp_alu_pipe.sv
// Scoreboard bench for pdp_alu_pipe (DATA_W=16, STAGES=2); byte vectors run only when
// PDP_ALU_BYTE_EN is defined.
module tb_pdp_alu_pipe;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned STAGES = 2;
    localparam int unsigned OPC_W  = 4;

    logic              clock;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [OPC_W-1:0]  in_op;
    logic              in_byte;
    logic [DATA_W-1:0] in_src;
    logic [3:0]        in_psw;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic [3:0]        out_psw;
    logic              out_illegal;
    logic [1:0]        occupancy;

    pdp_alu_pipe #(
        .DATA_W (DATA_W),
        .STAGES (STAGES),
        .OPC_W  (OPC_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_byte     (in_byte),
        .in_src      (in_src),
        .in_psw      (in_psw),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_psw     (out_psw),
        .out_illegal (out_illegal),
        .occupancy   (occupancy)
    );

    typedef struct {
        string       name;
        logic [15:0] res;
        logic [3:0]  psw;
        logic        ill;
        int          cyc;
        bit          lat;
    } exp_t;

    exp_t sb[$];
    int   n_cmp;
    int   n_err;
    int   cyc;
    bit   check_lat;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compares whatever the DUT presents against the oldest expected entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (!reset && out_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected output", 32'(out_valid), 32'd0);
                end else begin
                    e = sb[0];
                    check({e.name, " out"}, {11'd0, out_illegal, out_psw, out_result},
                          {11'd0, e.ill, e.psw, e.res});
                    if (out_ready) begin
                        void'(sb.pop_front());
                        if (e.lat) check({e.name, " latency"}, 32'(cyc - e.cyc), STAGES);
                    end
                end
            end
        end
    end

    task automatic send(input string name, input logic [3:0] op, input logic b,
                        input logic [15:0] src, input logic [3:0] psw,
                        input logic [15:0] eres, input logic [3:0] epsw, input logic eill);
        exp_t e;
        int   n;
        in_valid = 1'b1;
        in_op    = op;
        in_byte  = b;
        in_src   = src;
        in_psw   = psw;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!in_ready && n < 100);
        if (!in_ready) begin
            check({name, " accept"}, 32'(in_ready), 32'd1);
        end else begin
            e.name = name;
            e.res  = eres;
            e.psw  = epsw;
            e.ill  = eill;
            e.cyc  = cyc;
            e.lat  = check_lat;
            sb.push_back(e);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clock);
            n++;
        end
        check("drain", 32'(sb.size()), 32'd0);
        @(posedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        cyc       = 0;
        check_lat = 1'b1;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_op     = '0;
        in_byte   = 1'b0;
        in_src    = '0;
        in_psw    = '0;
        out_ready = 1'b1;

        repeat (2) @(negedge clock);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset occupancy", 32'(occupancy), 32'd0);
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_result", 32'(out_result), 32'd0);
        check("reset out_psw", 32'(out_psw), 32'd0);
        check("reset out_illegal", 32'(out_illegal), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Single directed vectors.
        send("INC 7FFF",  4'd2,  1'b0, 16'h7FFF, 4'b0001, 16'h8000, 4'b1011, 1'b0);
        send("NEG 0",     4'd4,  1'b0, 16'h0000, 4'b0000, 16'h0000, 4'b0100, 1'b0);
        send("ROR 1",     4'd8,  1'b0, 16'h0001, 4'b0000, 16'h0000, 4'b0111, 1'b0);
        send("NEG 8000",  4'd4,  1'b0, 16'h8000, 4'b0000, 16'h8000, 4'b1011, 1'b0);
        send("NEG 1",     4'd4,  1'b0, 16'h0001, 4'b0000, 16'hFFFF, 4'b1001, 1'b0);
        send("ROR c1",    4'd8,  1'b0, 16'h0002, 4'b0001, 16'h8001, 4'b1010, 1'b0);
        send("ASL 4000",  4'd11, 1'b0, 16'h4000, 4'b0000, 16'h8000, 4'b1010, 1'b0);
        send("SWAB 12F0", 4'd12, 1'b0, 16'h12F0, 4'b1111, 16'hF012, 4'b0000, 1'b0);
        send("SWAB 8000", 4'd12, 1'b1, 16'h8000, 4'b0000, 16'h0080, 4'b1000, 1'b0);
        send("ILL 15",    4'd15, 1'b0, 16'hBEEF, 4'b1010, 16'hBEEF, 4'b1010, 1'b1);
        send("ILL 13",    4'd13, 1'b0, 16'h0001, 4'b0101, 16'h0001, 4'b0101, 1'b1);
`ifdef PDP_ALU_BYTE_EN
        send("INCB AB7F", 4'd2,  1'b1, 16'hAB7F, 4'b0001, 16'hAB80, 4'b1011, 1'b0);
        send("DECB 1200", 4'd3,  1'b1, 16'h1200, 4'b0000, 16'h12FF, 4'b1000, 1'b0);
        send("COMB 12FF", 4'd1,  1'b1, 16'h12FF, 4'b0000, 16'h1200, 4'b0101, 1'b0);
        send("ADCB 34FF", 4'd5,  1'b1, 16'h34FF, 4'b0001, 16'h3400, 4'b0101, 1'b0);
`else
        send("INC byte-ignored", 4'd2, 1'b1, 16'hAB7F, 4'b0001, 16'hAB80, 4'b1001, 1'b0);
`endif
        idle();
        wait_drain();

        // Back-to-back stream, one op per cycle.
        send("S CLR", 4'd0,  1'b0, 16'h1234, 4'b1111, 16'h0000, 4'b0100, 1'b0);
        send("S COM", 4'd1,  1'b0, 16'h00FF, 4'b0000, 16'hFF00, 4'b1001, 1'b0);
        send("S DEC", 4'd3,  1'b0, 16'h8000, 4'b0000, 16'h7FFF, 4'b0010, 1'b0);
        send("S ADC", 4'd5,  1'b0, 16'hFFFF, 4'b0001, 16'h0000, 4'b0101, 1'b0);
        send("S SBC", 4'd6,  1'b0, 16'h0000, 4'b0001, 16'hFFFF, 4'b1001, 1'b0);
        send("S TST", 4'd7,  1'b0, 16'h8001, 4'b0011, 16'h8001, 4'b1000, 1'b0);
        send("S ROL", 4'd9,  1'b0, 16'h8000, 4'b0000, 16'h0000, 4'b0111, 1'b0);
        send("S ASR", 4'd10, 1'b0, 16'h8001, 4'b0000, 16'hC000, 4'b1001, 1'b0);
        idle();
        wait_drain();

        // Back-pressure: fill the pipe, hold out_ready low for 5 cycles, then release.
        check_lat = 1'b0;
        out_ready = 1'b0;
        send("P INC", 4'd2, 1'b0, 16'h0010, 4'b0000, 16'h0011, 4'b0000, 1'b0);
        send("P DEC", 4'd3, 1'b0, 16'h0001, 4'b0001, 16'h0000, 4'b0101, 1'b0);
        in_valid = 1'b1;
        in_op    = 4'd1;
        in_src   = 16'hFFFF;
        in_psw   = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("stall occupancy", 32'(occupancy), 32'd2);
            check("stall in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clock);
        #1;
        out_ready = 1'b1;
        send("P COM", 4'd1, 1'b0, 16'hFFFF, 4'b0000, 16'h0000, 4'b0101, 1'b0);
        idle();
        wait_drain();
        check_lat = 1'b1;

        // Asynchronous reset with two ops in flight.
        send("R A", 4'd7, 1'b0, 16'h0005, 4'b0000, 16'h0005, 4'b0000, 1'b0);
        send("R B", 4'd7, 1'b0, 16'h0006, 4'b0000, 16'h0006, 4'b0000, 1'b0);
        idle();
        reset = 1'b1;
        #1;
        check("flush out_valid", 32'(out_valid), 32'd0);
        check("flush occupancy", 32'(occupancy), 32'd0);
        sb.delete();
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("post-reset in_ready", 32'(in_ready), 32'd1);
        send("after reset", 4'd2, 1'b0, 16'hFFFF, 4'b0000, 16'h0000, 4'b0100, 1'b0);
        idle();
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
